// File: rtl/xversat_databus_merge_if.sv
// Databus channel bundle (requesting channels = master) and native memory port (merge block = master).
// Both interfaces carry plain signals only; flow control is valid/ready pulses.
`timescale 1ns/1ps
interface xversat_databus_if #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATABUS_W = 256
);
  logic [N_MASTERS-1:0]               databus_valid;
  logic [N_MASTERS*ADDR_W-1:0]        databus_addr;
  logic [N_MASTERS*DATABUS_W-1:0]     databus_wdata;
  logic [N_MASTERS*DATABUS_W/8-1:0]   databus_wstrb;
  logic [N_MASTERS-1:0]               databus_ready;
  logic [N_MASTERS*DATABUS_W-1:0]     databus_rdata;

  modport master (
    output databus_valid, databus_addr, databus_wdata, databus_wstrb,
    input  databus_ready, databus_rdata
  );
  modport slave (
    input  databus_valid, databus_addr, databus_wdata, databus_wstrb,
    output databus_ready, databus_rdata
  );
endinterface

interface xversat_mem_if #(
  parameter int ADDR_W    = 32,
  parameter int DATABUS_W = 256
);
  logic                   m_valid;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATABUS_W-1:0]   m_wdata;
  logic [DATABUS_W/8-1:0] m_wstrb;
  logic                   m_ready;
  logic [DATABUS_W-1:0]   m_rdata;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata
  );
  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/xversat_databus_merge.sv
// Merges N databus channels onto one memory port, one outstanding transaction, valid->m_valid 1 cycle, one idle bubble each.
// Losing channels wait with valid held; round-robin by default, XVERSAT_MERGE_FIXED_PRIO_EN gives lowest-index priority.
`timescale 1ns/1ps
module xversat_databus_merge #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATABUS_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  xversat_databus_if.slave db,
  xversat_mem_if.master    mem
);

  localparam int STRB_W = DATABUS_W / 8;
  localparam int GW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic                  m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
  logic [DATABUS_W-1:0]  m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]     m_wstrb_q, m_wstrb_d;

  logic                  win_vld;
  logic [GW-1:0]         win_idx;
  logic [N_MASTERS-1:0]  ready;

`ifdef XVERSAT_MERGE_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    // Scan downward so the lowest requesting index is the last write.
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (db.databus_valid[k]) begin
        win_vld = 1'b1;
        win_idx = GW'(k);
      end
    end
  end
`else
  logic [GW-1:0] last_q, last_d;
  logic [GW:0]   rr_sum;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    // Candidates last+N down to last+1 (mod N): the final hit is the first one upward from last+1.
    for (int k = N_MASTERS; k >= 1; k--) begin
      rr_sum = {1'b0, last_q} + (GW+1)'(k);
      if (rr_sum >= (GW+1)'(N_MASTERS)) begin
        rr_sum = rr_sum - (GW+1)'(N_MASTERS);
      end
      if (db.databus_valid[rr_sum[GW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = rr_sum[GW-1:0];
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
`ifndef XVERSAT_MERGE_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = BUSY;
          grant_d   = win_idx;
          m_valid_d = 1'b1;
          m_addr_d  = db.databus_addr[win_idx*ADDR_W +: ADDR_W];
          m_wdata_d = db.databus_wdata[win_idx*DATABUS_W +: DATABUS_W];
          m_wstrb_d = db.databus_wstrb[win_idx*STRB_W +: STRB_W];
        end
      end
      BUSY: begin
        // Completion is taken regardless of the channel's current valid.
        if (mem.m_ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
`ifndef XVERSAT_MERGE_FIXED_PRIO_EN
          last_d    = grant_q;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
`ifndef XVERSAT_MERGE_FIXED_PRIO_EN
      last_q    <= GW'(N_MASTERS - 1);
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
`ifndef XVERSAT_MERGE_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  // m_ready in IDLE never reaches a channel.
  always_comb begin
    ready = '0;
    if (state_q == BUSY && mem.m_ready) begin
      ready[grant_q] = 1'b1;
    end
  end

  assign db.databus_ready = ready;
  assign db.databus_rdata = {N_MASTERS{mem.m_rdata}};

  assign mem.m_valid = m_valid_q;
  assign mem.m_addr  = m_addr_q;
  assign mem.m_wdata = m_wdata_q;
  assign mem.m_wstrb = m_wstrb_q;

endmodule

// File: tb/tb_xversat_databus_merge.sv
// Bench for xversat_databus_merge: directed channel/memory stimulus, behavioural arbiter model compared every cycle.
`timescale 1ns/1ps
module tb_xversat_databus_merge;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xversat_databus_if #(.N_MASTERS(N), .ADDR_W(AW), .DATABUS_W(DW)) db();
  xversat_mem_if     #(.ADDR_W(AW), .DATABUS_W(DW))                 mem();

  xversat_databus_merge #(.N_MASTERS(N), .ADDR_W(AW), .DATABUS_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .db  (db),
    .mem (mem)
  );

  // Channel request drivers
  logic [N-1:0]  req_vld;
  logic [AW-1:0] req_addr  [N];
  logic [DW-1:0] req_wdata [N];
  logic [SW-1:0] req_wstrb [N];

  assign db.databus_valid = req_vld;
  for (genvar g = 0; g < N; g++) begin : g_drv
    assign db.databus_addr [g*AW +: AW] = req_addr[g];
    assign db.databus_wdata[g*DW +: DW] = req_wdata[g];
    assign db.databus_wstrb[g*SW +: SW] = req_wstrb[g];
  end

  // Memory responder: m_ready pulses mem_lat cycles after the first m_valid cycle
  int            mem_lat  = 1;
  int            vcnt     = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rdy_r    = 1'b0;
  logic          spurious = 1'b0;

  assign mem.m_ready = rdy_r | spurious;
  assign mem.m_rdata = mem_rdata;

  always @(posedge clk) begin
    #1;
    if (!rst || !mem.m_valid) vcnt = 0;
    else vcnt = vcnt + 1;
    rdy_r = (vcnt == mem_lat + 1);
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: one owner at a time, winner by rotating priority
  int            mdl_busy  = 0;
  int            mdl_owner = 0;
  int            mdl_last  = N - 1;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_wdata;
  logic [SW-1:0] mdl_wstrb;
  int            log_ch  [$];
  int            log_cyc [$];

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int           c;
    bit           found;
    if (!rst) begin
      mdl_busy = 0;
      mdl_last = N - 1;
      check("mdl_rst_m_valid", mem.m_valid, 0);
      check("mdl_rst_ready", db.databus_ready, 0);
    end else begin
      exp_rdy = '0;
      if (mdl_busy != 0 && mem.m_ready) exp_rdy[mdl_owner] = 1'b1;
      check("mdl_m_valid", mem.m_valid, (mdl_busy != 0));
      if (mdl_busy != 0) begin
        check("mdl_m_addr",  mem.m_addr,  mdl_addr);
        check("mdl_m_wdata", mem.m_wdata, mdl_wdata);
        check("mdl_m_wstrb", mem.m_wstrb, mdl_wstrb);
      end
      check("mdl_ready", db.databus_ready, exp_rdy);
      if (exp_rdy != 0) begin
        check("mdl_rdata", db.databus_rdata[mdl_owner*DW +: DW], mem_rdata);
        log_ch.push_back(mdl_owner);
        log_cyc.push_back(cyc);
      end
      if (mdl_busy != 0) begin
        if (mem.m_ready) begin
          mdl_busy = 0;
          mdl_last = mdl_owner;
        end
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
`ifdef XVERSAT_MERGE_FIXED_PRIO_EN
          c = k;
`else
          c = (mdl_last + 1 + k) % N;
`endif
          if (!found && req_vld[c]) begin
            found     = 1;
            mdl_busy  = 1;
            mdl_owner = c;
            mdl_addr  = req_addr[c];
            mdl_wdata = req_wdata[c];
            mdl_wstrb = req_wstrb[c];
          end
        end
      end
    end
  end

  task automatic wait_ready(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!db.databus_ready[ch] && n < 60);
    check($sformatf("wait_ready_ch%0d", ch), db.databus_ready[ch], 1);
  endtask

  task automatic drop(input int ch);
    @(posedge clk); #1;
    req_vld[ch] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int exp_order [6];
    req_vld = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_wstrb[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", mem.m_valid, 0);
    check("rst_m_addr",  mem.m_addr, 0);
    check("rst_m_wstrb", mem.m_wstrb, 0);
    check("rst_ready",   db.databus_ready, 0);
    @(posedge clk); #3 rst = 1'b1;

    // Single read on ch0
    @(posedge clk); #1;
    mem_lat = 3; mem_rdata = {32{8'hA5}};
    req_addr[0] = 32'h100; req_wstrb[0] = '0; req_vld[0] = 1'b1;
    @(negedge clk);
    check("rd_m_valid_before_edge", mem.m_valid, 0);
    @(negedge clk);
    check("rd_m_valid_lat1", mem.m_valid, 1);
    check("rd_m_addr", mem.m_addr, 32'h100);
    wait_ready(0, n);
    check("rd_ready_lat", n, 3);
    check("rd_rdata", db.databus_rdata[0 +: DW], {32{8'hA5}});
    check("rd_other_ready", db.databus_ready[2:1], 2'b00);
    drop(0);

    // Protocol violation: ch1 drops valid while BUSY, completion still delivered
    @(posedge clk); #1;
    mem_lat = 3; mem_rdata = {8{32'h0BAD_F00D}};
    req_addr[1] = 32'h300; req_wstrb[1] = {SW{1'b1}}; req_wdata[1] = 256'h77; req_vld[1] = 1'b1;
    @(negedge clk); @(negedge clk);
    check("pv_m_addr", mem.m_addr, 32'h300);
    @(posedge clk); #1 req_vld[1] = 1'b0;
    wait_ready(1, n);
    check("pv_rdata", db.databus_rdata[DW +: DW], {8{32'h0BAD_F00D}});

    // Write passthrough on ch2
    repeat (2) @(posedge clk); #1;
    mem_lat = 2;
    base = log_ch.size();
    req_addr[2] = 32'h2000; req_wdata[2] = 256'h1234; req_wstrb[2] = {SW{1'b1}}; req_vld[2] = 1'b1;
    @(negedge clk); @(negedge clk);
    check("wr_m_addr",  mem.m_addr, 32'h2000);
    check("wr_m_wdata", mem.m_wdata, 256'h1234);
    check("wr_m_wstrb", mem.m_wstrb, {SW{1'b1}});
    @(negedge clk);
    check("wr_m_wdata_held", mem.m_wdata, 256'h1234);
    wait_ready(2, n);
    drop(2);
    repeat (4) @(posedge clk);
    check("wr_single_pulse", log_ch.size() - base, 1);
    if (log_ch.size() > base) check("wr_pulse_ch", log_ch[base], 2);

    // Contention: all three requesting continuously, memory answers 1 cycle after m_valid
    @(posedge clk); #1;
    mem_lat = 1; mem_rdata = {4{64'hC0FF_EE00_1122_3344}};
    for (int i = 0; i < N; i++) begin
      req_addr[i] = 32'h4000 + 32'(i * 16); req_wdata[i] = 256'(i + 1); req_wstrb[i] = SW'(i);
    end
    base = log_ch.size();
    req_vld = '1;
    n = 0;
    while (log_ch.size() < base + 6 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    req_vld = '0;
    check("cont_six_grants", (log_ch.size() >= base + 6), 1);
`ifdef XVERSAT_MERGE_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 6; i++) begin
      if (log_ch.size() > base + i) begin
        check($sformatf("cont_order_%0d", i), log_ch[base + i], exp_order[i]);
        if (i > 0) check($sformatf("cont_gap_%0d", i), log_cyc[base + i] - log_cyc[base + i - 1], 3);
      end
    end
    repeat (3) @(posedge clk);
    check("cont_no_extra", log_ch.size() - base, 6);

`ifdef XVERSAT_MERGE_FIXED_PRIO_EN
    // Fixed priority: ch0 starves ch2 until released
    @(posedge clk); #1;
    base = log_ch.size();
    req_vld = 3'b101;
    n = 0;
    while (log_ch.size() < base + 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    req_vld[0] = 1'b0;
    for (int i = 0; i < 3; i++)
      if (log_ch.size() > base + i) check($sformatf("fp_ch0_%0d", i), log_ch[base + i], 0);
    wait_ready(2, n);
    drop(2);
`endif

    // Reset asserted while BUSY for ch1
    @(posedge clk); #1;
    mem_lat = 10;
    req_addr[1] = 32'h5000; req_vld[1] = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rb_m_valid_busy", mem.m_valid, 1);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("rb_async_m_valid", mem.m_valid, 0);
    check("rb_async_ready", db.databus_ready, 0);
    req_addr[0] = 32'h6000; req_vld[0] = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    base = log_ch.size();
    wait_ready(0, n);
    drop(0);
    check("rb_first_grant_ch0", (log_ch.size() > base) ? log_ch[base] : -1, 0);
    wait_ready(1, n);
    drop(1);

    // Spurious m_ready in IDLE
    repeat (3) @(posedge clk); #1;
    spurious = 1'b1;
    @(negedge clk);
    check("sp_ready", db.databus_ready, 3'b000);
    @(posedge clk); #1 spurious = 1'b0;
    @(negedge clk);
    check("sp_stays_idle", mem.m_valid, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
